audio_stream_seq: RTL and testbench
===================================

AUDIO_STREAM_SEQ -- requirements
Module: audio_stream_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 23: flash word-address width.
REQ-002 The block SHALL have parameter WORD_W, default 32: flash data width.
REQ-003 The block SHALL have parameter SAMPLE_W, default 8: sample width; WORD_W SHALL be an integer multiple of it, with N = WORD_W/SAMPLE_W lanes; lane k = flash_data[k*SAMPLE_W +: SAMPLE_W].
REQ-004 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1: level; high = play/continue.
REQ-007 The block SHALL have port dir, input, 1: 0 = forward, 1 = reverse.
REQ-008 The block SHALL have port restart, input, 1: one-cycle request to jump to the range start.
REQ-009 The block SHALL have port loop_en, input, 1: 1 = wrap at range end; 0 = stop at range end.
REQ-010 The block SHALL have ports addr_lo and addr_hi, input, ADDR_W: inclusive playback range, with addr_lo <= addr_hi.
REQ-011 The block SHALL have port sample_tick, input, 1: one-cycle sample-rate strobe, already synchronous to clk.
REQ-012 The block SHALL have port flash_read, output, 1: flash read request.
REQ-013 The block SHALL have port flash_addr, output, ADDR_W: flash word address.
REQ-014 The block SHALL have port flash_done, input, 1: one-cycle pulse marking flash_data valid.
REQ-015 The block SHALL have port flash_data, input, WORD_W: flash read data.
REQ-016 The block SHALL have port sample_out, output, SAMPLE_W: current sample to the audio path.
REQ-017 The block SHALL have port sample_valid, output, 1: one-cycle pulse when sample_out updates.
REQ-018 The block SHALL have port word_done, output, 1: one-cycle pulse when the address advances.
REQ-019 The block SHALL have port play_end, output, 1: one-cycle pulse on a one-shot stop at range end.
REQ-020 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-021 The state machine SHALL have states IDLE, FETCH, PLAY and ADVANCE; busy = (state != IDLE).
REQ-022 In IDLE, start=1 SHALL move to FETCH; on that edge, if a restart is pending or flash_addr is outside [addr_lo, addr_hi], flash_addr SHALL load addr_lo (dir=0) or addr_hi (dir=1).
REQ-023 flash_read SHALL be 1 exactly while in FETCH, with flash_addr stable throughout FETCH.
REQ-024 In FETCH, flash_done SHALL latch flash_data into an internal word buffer, latch dir into dir_q, set the lane index to 0 (dir_q=0) or N-1 (dir_q=1), and move to PLAY.
REQ-025 In PLAY, each sample_tick SHALL drive sample_out <= buffer lane[index], pulse sample_valid in the next cycle, and step the index +1 (dir_q=0) or -1 (dir_q=1); the tick that plays the last lane SHALL move to ADVANCE.
REQ-026 A sample_tick outside PLAY SHALL be ignored; the first sample of a new word SHALL play only on a tick received in PLAY.
REQ-027 flash_done outside FETCH SHALL be ignored.
REQ-028 In ADVANCE (one cycle), word_done SHALL pulse; forward: restart pending -> addr_lo; flash_addr == addr_hi -> addr_lo (wrap event); otherwise flash_addr+1.
REQ-029 In ADVANCE, reverse SHALL be symmetric: restart pending -> addr_hi; flash_addr == addr_lo -> addr_hi (wrap event); otherwise flash_addr-1; dir_q SHALL be used throughout.
REQ-030 The next state from ADVANCE SHALL be: wrap event with loop_en=0 -> IDLE with play_end pulsed; else start=1 -> FETCH; else IDLE.
REQ-031 restart SHALL set a sticky pending flag that is cleared when applied (REQ-022/028); restart in the same cycle as its application SHALL apply immediately; a restart-driven jump SHALL NOT be a wrap event.
REQ-032 With addr_lo == addr_hi, every ADVANCE SHALL be a wrap event.
REQ-033 Address arithmetic SHALL be ADDR_W-bit; the range checks SHALL prevent any modular overflow from being reachable.
REQ-034 A dir change SHALL take effect only at the next FETCH completion.
REQ-035 sample_out SHALL hold its value between sample_valid pulses.

Reset
REQ-036 While rst_n=0, the block SHALL set state=IDLE, flash_addr=0, flash_read=0, sample_out=0, sample_valid=0, word_done=0, play_end=0, busy=0, restart pending=0, lane index=0 and buffer=0.
REQ-037 Reset asserted mid-FETCH or mid-PLAY SHALL abort immediately; a late flash_done SHALL be ignored.

Verification
REQ-038 Forward: lo=0, hi=3, start=1, flash_data=0x44332211, 4 ticks -> sample_out 0x11, 0x22, 0x33, 0x44 with 4 sample_valid pulses, then word_done and flash_addr=1.
REQ-039 Reverse: same word, dir=1, flash_addr=2 -> samples 0x44, 0x33, 0x22, 0x11, then flash_addr=1.
REQ-040 Wrap/one-shot: flash_addr=3, hi=3, loop_en=1 -> flash_addr=0 with no play_end; loop_en=0 -> flash_addr=0, play_end pulse, state IDLE.
REQ-041 Restart: restart pulsed during PLAY at flash_addr=5 (lo=2, hi=9, forward) -> at ADVANCE flash_addr=2, no play_end, pending cleared.
REQ-042 Tick filtering: 3 ticks during FETCH -> no sample_valid; the first sample appears only after flash_done plus a tick.
REQ-043 Reset mid-PLAY: rst_n low after 2 samples -> all outputs at their reset values at once; a flash_done pulse after release -> no effect.

Source files
------------

// File: rtl/audio_stream_seq.sv
// rtl/audio_stream_seq.sv - flash-backed audio sample sequencer
// Fetches one flash word per step and plays its lanes on sample ticks over an address range.
module audio_stream_seq #(
    parameter int ADDR_W   = 23,
    parameter int WORD_W   = 32,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dir,
    input  logic                restart,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   addr_lo,
    input  logic [ADDR_W-1:0]   addr_hi,
    input  logic                sample_tick,
    output logic                flash_read,
    output logic [ADDR_W-1:0]   flash_addr,
    input  logic                flash_done,
    input  logic [WORD_W-1:0]   flash_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                word_done,
    output logic                play_end,
    output logic                busy
);

    localparam int N     = WORD_W / SAMPLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PLAY    = 2'd2,
        S_ADVANCE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                dir_q, dir_d;
    logic                pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [SAMPLE_W-1:0] sout_q, sout_d;

    logic pend_eff;
    logic in_range;
    logic at_end;
    logic wrap;
    logic last_lane;

    // A restart arriving in the cycle it would be applied counts as already pending.
    assign pend_eff  = pend_q | restart;
    assign in_range  = (addr_q >= addr_lo) && (addr_q <= addr_hi);
    assign at_end    = dir_q ? (addr_q <= addr_lo) : (addr_q >= addr_hi);
    assign wrap      = !pend_eff && at_end;
    assign last_lane = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   if (flash_done) state_d = S_PLAY;
            S_PLAY:    if (sample_tick && last_lane) state_d = S_ADVANCE;
            S_ADVANCE: begin
                if (wrap && !loop_en) state_d = S_IDLE;
                else if (start)       state_d = S_FETCH;
                else                  state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flash_read = (state_q == S_FETCH);
        busy       = (state_q != S_IDLE);
        word_done  = (state_q == S_ADVANCE);
        play_end   = (state_q == S_ADVANCE) && wrap && !loop_en;
    end

    always_comb begin
        addr_d  = addr_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        pend_d  = pend_q | restart;
        valid_d = 1'b0;
        sout_d  = sout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (pend_eff || !in_range) addr_d = dir ? addr_hi : addr_lo;
                    pend_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (flash_done) begin
                    buf_d = flash_data;
                    dir_d = dir;
                    idx_d = dir ? LAST_IDX : '0;
                end
            end
            S_PLAY: begin
                if (sample_tick) begin
                    sout_d  = buf_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
                    valid_d = 1'b1;
                    idx_d   = dir_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
                end
            end
            S_ADVANCE: begin
                pend_d = 1'b0;
                // Range-end compare uses >=/<= so a stale address can never step past the bounds.
                if (pend_eff || at_end) addr_d = dir_q ? addr_hi : addr_lo;
                else                    addr_d = dir_q ? (addr_q - 1'b1) : (addr_q + 1'b1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            sout_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            sout_q  <= sout_d;
        end
    end

    assign flash_addr   = addr_q;
    assign sample_out   = sout_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_audio_stream_seq.sv
// tb/tb_audio_stream_seq.sv - self-checking bench for audio_stream_seq
// Transaction-level model predicts fetch addresses, samples, next addresses and play_end.
module tb_audio_stream_seq;

    localparam int AW = 23;
    localparam int WW = 32;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic          restart = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] addr_lo = '0;
    logic [AW-1:0] addr_hi = '0;
    logic          sample_tick = 1'b0;
    logic          flash_done = 1'b0;
    logic [WW-1:0] flash_data = '0;
    logic          flash_read;
    logic [AW-1:0] flash_addr;
    logic [SW-1:0] sample_out;
    logic          sample_valid;
    logic          word_done;
    logic          play_end;
    logic          busy;

    audio_stream_seq #(.ADDR_W(AW), .WORD_W(WW), .SAMPLE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .restart(restart),
        .loop_en(loop_en), .addr_lo(addr_lo), .addr_hi(addr_hi),
        .sample_tick(sample_tick), .flash_read(flash_read), .flash_addr(flash_addr),
        .flash_done(flash_done), .flash_data(flash_data), .sample_out(sample_out),
        .sample_valid(sample_valid), .word_done(word_done), .play_end(play_end), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int lat = 5;
    int manual_req = 0;
    int manual_ack = 0;
    int sv_cnt = 0;
    int pe_cnt = 0;

    logic [SW-1:0] exp_samp[$];
    logic [AW-1:0] exp_fetch[$];
    logic [AW-1:0] exp_next[$];
    bit            exp_pe[$];
    logic [SW-1:0] seen_q[$];
    logic [AW-1:0] m_addr = '0;
    bit            m_pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (a < 4) return 32'h44332211;
        return {b + 8'h30, b + 8'h20, b + 8'h10, b};
    endfunction

    // Flash responder: answers each FETCH after 'lat' cycles; manual pulses model a stray flash_done.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            flash_done = 1'b0;
            if (manual_req != manual_ack) begin
                flash_done = 1'b1;
                flash_data = 32'hDEADBEEF;
                manual_ack = manual_req;
            end else if (flash_read && rst_n) begin
                cnt++;
                if (cnt >= lat) begin
                    flash_done = 1'b1;
                    flash_data = word_of(flash_addr);
                    cnt = 0;
                    done_cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            ph = (ph + 1) % 3;
            sample_tick = (ph == 0);
        end
    end

    initial begin
        logic [SW-1:0] last_s;
        logic [AW-1:0] fa;
        bit prev_read, chk_next;
        last_s = '0; fa = '0; prev_read = 1'b0; chk_next = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_s = '0; prev_read = 1'b0; chk_next = 1'b0;
            end else begin
                if (chk_next) begin
                    chk_next = 1'b0;
                    if (exp_next.size() == 0) chk("next_addr_unexpected", 64'(flash_addr), 64'hFFFF_FFFF);
                    else chk("next_addr", 64'(flash_addr), 64'(exp_next.pop_front()));
                end
                if (sample_valid) begin
                    sv_cnt++;
                    seen_q.push_back(sample_out);
                    if (exp_samp.size() == 0) chk("sample_unexpected", 64'(sample_out), 64'h1FF);
                    else begin
                        last_s = exp_samp.pop_front();
                        chk("sample", 64'(sample_out), 64'(last_s));
                    end
                end
                chk("sample_hold", 64'(sample_out), 64'(last_s));
                if (flash_read) begin
                    if (!prev_read) begin
                        if (exp_fetch.size() == 0) begin
                            chk("fetch_unexpected", 64'(flash_addr), 64'hFFFF_FFFF);
                            fa = flash_addr;
                        end else fa = exp_fetch.pop_front();
                    end
                    chk("fetch_addr", 64'(flash_addr), 64'(fa));
                    chk("valid_in_fetch", 64'(sample_valid), 64'd0);
                    chk("busy_in_fetch", 64'(busy), 64'd1);
                end
                if (word_done) begin
                    chk_next = 1'b1;
                    if (play_end) pe_cnt++;
                    if (exp_pe.size() == 0) chk("word_done_unexpected", 64'(word_done), 64'd0);
                    else chk("play_end", 64'(play_end), 64'(exp_pe.pop_front()));
                end else if (play_end) begin
                    chk("play_end_outside_advance", 64'(play_end), 64'd0);
                end
                prev_read = flash_read;
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic plan(input int n, input bit rst_last);
        if (m_pend || m_addr < addr_lo || m_addr > addr_hi) m_addr = dir ? addr_hi : addr_lo;
        m_pend = 1'b0;
        for (int w = 0; w < n; w++) begin
            logic [WW-1:0] d;
            bit rs, wr;
            exp_fetch.push_back(m_addr);
            d = word_of(m_addr);
            for (int k = 0; k < 4; k++) begin
                int lane;
                lane = dir ? 3 - k : k;
                exp_samp.push_back(d[lane*8 +: 8]);
            end
            rs = rst_last && (w == n - 1);
            wr = !rs && (dir ? (m_addr == addr_lo) : (m_addr == addr_hi));
            if (rs || wr) m_addr = dir ? addr_hi : addr_lo;
            else          m_addr = dir ? m_addr - 1'b1 : m_addr + 1'b1;
            exp_next.push_back(m_addr);
            exp_pe.push_back(wr && !loop_en);
        end
    endtask

    task automatic run_words(input int n, input bit rst_last);
        int target, t;
        plan(n, rst_last);
        target = done_cnt + n;
        start = 1'b1;
        t = 0;
        while (done_cnt < target && t < 3000) begin step(); t++; end
        if (done_cnt < target) chk("timeout_fetch", 64'(done_cnt), 64'(target));
        start = 1'b0;
        if (rst_last) begin
            repeat (3) step();
            restart = 1'b1;
            step();
            restart = 1'b0;
        end
        t = 0;
        while (busy && t < 3000) begin step(); t++; end
        if (busy) chk("timeout_idle", 64'(busy), 64'd0);
        step();
        chk("queues_drained", 64'(exp_samp.size() + exp_fetch.size() + exp_next.size()), 64'd0);
    endtask

    function automatic logic [31:0] last4();
        int s;
        s = seen_q.size();
        if (s < 4) return 32'hFFFF_FFFF;
        return {seen_q[s-4], seen_q[s-3], seen_q[s-2], seen_q[s-1]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flash_read"},   64'(flash_read), 64'd0);
        chk({tag, "_flash_addr"},   64'(flash_addr), 64'd0);
        chk({tag, "_sample_out"},   64'(sample_out), 64'd0);
        chk({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
        chk({tag, "_word_done"},    64'(word_done), 64'd0);
        chk({tag, "_play_end"},     64'(play_end), 64'd0);
        chk({tag, "_busy"},         64'(busy), 64'd0);
    endtask

    initial begin
        int pe0, base, t;
        repeat (3) step();
        check_reset_outputs("reset");
        addr_lo = 0; addr_hi = 3; loop_en = 1'b1; dir = 1'b0;
        rst_n = 1'b1;
        step();

        run_words(1, 1'b0);
        chk("fwd_samples", 64'(last4()), 64'h11223344);
        chk("fwd_addr", 64'(flash_addr), 64'd1);
        chk("fwd_hold", 64'(sample_out), 64'h44);

        run_words(1, 1'b0);
        dir = 1'b1;
        run_words(1, 1'b0);
        chk("rev_samples", 64'(last4()), 64'h44332211);
        chk("rev_addr", 64'(flash_addr), 64'd1);

        dir = 1'b0;
        pe0 = pe_cnt;
        run_words(5, 1'b0);
        chk("loop_wrap_no_end", 64'(pe_cnt), 64'(pe0));
        chk("loop_addr", 64'(flash_addr), 64'd2);
        loop_en = 1'b0;
        run_words(2, 1'b0);
        chk("oneshot_addr", 64'(flash_addr), 64'd0);
        chk("oneshot_play_end", 64'(pe_cnt), 64'(pe0 + 1));
        chk("oneshot_idle", 64'(busy), 64'd0);

        addr_lo = 2; addr_hi = 9; loop_en = 1'b1;
        run_words(3, 1'b0);
        chk("range_load_addr", 64'(flash_addr), 64'd5);
        pe0 = pe_cnt;
        run_words(1, 1'b1);
        chk("restart_addr", 64'(flash_addr), 64'd2);
        chk("restart_no_end", 64'(pe_cnt), 64'(pe0));
        run_words(1, 1'b0);
        chk("restart_cleared", 64'(flash_addr), 64'd3);
        restart = 1'b1;
        step();
        restart = 1'b0;
        m_pend = 1'b1;
        dir = 1'b1;
        run_words(1, 1'b0);
        chk("idle_restart_rev", 64'(flash_addr), 64'd8);

        addr_lo = 6; addr_hi = 6; dir = 1'b0;
        pe0 = pe_cnt;
        run_words(2, 1'b0);
        chk("single_loop_addr", 64'(flash_addr), 64'd6);
        loop_en = 1'b0;
        run_words(1, 1'b0);
        chk("single_oneshot_end", 64'(pe_cnt), 64'(pe0 + 1));

        addr_lo = 0; addr_hi = 3; loop_en = 1'b1; lat = 12;
        run_words(1, 1'b0);
        chk("slow_fetch_first", 64'(last4()), 64'h11223344);
        lat = 5;

        plan(1, 1'b0);
        base = sv_cnt;
        start = 1'b1;
        t = 0;
        while (sv_cnt < base + 2 && t < 3000) begin step(); t++; end
        if (sv_cnt < base + 2) chk("timeout_samples", 64'(sv_cnt), 64'(base + 2));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midplay");
        exp_samp.delete(); exp_fetch.delete(); exp_next.delete(); exp_pe.delete();
        m_addr = '0; m_pend = 1'b0;
        start = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        manual_req++;
        repeat (3) step();
        check_reset_outputs("late_done");
        chk("late_done_samples", 64'(sv_cnt), 64'(base + 2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
